// File: rtl/pc_redirect_unit.sv
// Fetch-PC sequencer: sequential instruction fetch, branch/jump redirect with
// a one-cycle flush, jal link write, and a sticky halt on a branch-unit warn.
module pc_redirect_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      RA_REG   = 5'd31
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_instr_req,
    input  logic            i_instr_valid,
    input  logic            i_stall,
    output logic [PC_W-1:0] o_pc_out,
    input  logic            i_br_valid,
    input  logic [31:0]     i_br_id,
    input  logic [PC_W-1:0] i_br_pc,
    input  logic [31:0]     i_br_out,
    input  logic            i_br_warn,
    output logic            o_flush,
    output logic            o_ra_we,
    output logic [4:0]      o_ra_addr,
    output logic [31:0]     o_ra_data,
    output logic            o_halted,
    output logic [15:0]     o_redirect_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FETCH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_HALT     = 2'd3;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_instr_req;
    logic            r_flush;
    logic            r_ra_we;
    logic [31:0]     r_ra_data;
    logic            r_halted;
    logic [15:0]     r_cnt;

    logic            w_in_fetch;
    logic            w_is_cond;
    logic            w_is_jump;
    logic            w_is_jal;
    logic            w_warn;
    logic            w_take;
    logic [PC_W-1:0] w_pc_link;
    logic [PC_W-1:0] w_target;

    // Decode the resolved branch; results outside FETCH belong to the flushed stream.
    always_comb begin
        w_in_fetch = (r_state == S_FETCH);
        w_is_cond  = (i_br_id >= 32'd15) && (i_br_id <= 32'd20);
        w_is_jump  = (i_br_id >= 32'd21) && (i_br_id <= 32'd23);
        w_is_jal   = (i_br_id == 32'd23);
        w_warn     = w_in_fetch && i_br_valid && i_br_warn;
        w_pc_link  = i_br_pc + PC_W'(1'b1);
        w_target   = i_br_out[PC_W-1:0];
        w_take     = 1'b0;
        if (w_in_fetch && i_br_valid && !i_br_warn) begin
            if (w_is_cond) begin
                w_target = w_pc_link + i_br_out[PC_W-1:0];
                w_take   = (i_br_out != 32'd0);
            end else if (w_is_jump) begin
                w_take = 1'b1;
            end else begin
                w_take = 1'b0;
            end
        end else begin
            w_take = 1'b0;
        end
    end

    // State machine and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr_req <= 1'b0;
            r_flush     <= 1'b0;
            r_ra_we     <= 1'b0;
            r_ra_data   <= 32'd0;
            r_halted    <= 1'b0;
            r_cnt       <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_FETCH;
                    r_instr_req <= 1'b1;
                end
                S_FETCH: begin
                    if (w_warn) begin
                        r_state     <= S_HALT;
                        r_instr_req <= 1'b0;
                        r_halted    <= 1'b1;
                    end else if (w_take) begin
                        r_state     <= S_REDIRECT;
                        r_pc        <= w_target;
                        r_instr_req <= 1'b0;
                        r_flush     <= 1'b1;
                        r_ra_we     <= w_is_jal;
                        if (w_is_jal) begin
                            r_ra_data <= 32'(w_pc_link);
                        end
                        if (r_cnt != 16'hFFFF) begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else if (i_instr_valid && !i_stall) begin
                        r_pc <= r_pc + PC_W'(1'b1);
                    end
                end
                S_REDIRECT: begin
                    r_state     <= S_FETCH;
                    r_instr_req <= 1'b1;
                    r_flush     <= 1'b0;
                    r_ra_we     <= 1'b0;
                end
                S_HALT: begin
                    r_state     <= S_HALT;
                    r_instr_req <= 1'b0;
                    r_halted    <= 1'b1;
                end
                default: begin
                    r_state     <= S_HALT;
                    r_instr_req <= 1'b0;
                    r_flush     <= 1'b0;
                    r_ra_we     <= 1'b0;
                    r_halted    <= 1'b1;
                end
            endcase
        end
    end

    assign o_instr_req    = r_instr_req;
    assign o_pc_out       = r_pc;
    assign o_flush        = r_flush;
    assign o_ra_we        = r_ra_we;
    assign o_ra_addr      = RA_REG;
    assign o_ra_data      = r_ra_data;
    assign o_halted       = r_halted;
    assign o_redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a 32-bit PC instance driven from a
// vector table, and an 8-bit PC instance for wrap-around arithmetic.
module tb_pc_redirect_unit;

    logic        clk;
    logic        reset;
    logic        reset_b;
    logic        instr_valid;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_id;
    logic [31:0] br_pc;
    logic [31:0] br_out;
    logic        br_warn;

    logic        a_req, a_flush, a_we, a_halted;
    logic [31:0] a_pc, a_rad;
    logic [4:0]  a_raddr;
    logic [15:0] a_cnt;

    logic        b_req, b_flush, b_we, b_halted;
    logic [7:0]  b_pc;
    logic [31:0] b_rad;
    logic [4:0]  b_raddr;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    pc_redirect_unit #(.PC_W(32)) dut_a (
        .i_clk(clk), .i_reset(reset), .o_instr_req(a_req),
        .i_instr_valid(instr_valid), .i_stall(stall), .o_pc_out(a_pc),
        .i_br_valid(br_valid), .i_br_id(br_id), .i_br_pc(br_pc),
        .i_br_out(br_out), .i_br_warn(br_warn), .o_flush(a_flush),
        .o_ra_we(a_we), .o_ra_addr(a_raddr), .o_ra_data(a_rad),
        .o_halted(a_halted), .o_redirect_cnt(a_cnt)
    );

    pc_redirect_unit #(.PC_W(8)) dut_b (
        .i_clk(clk), .i_reset(reset_b), .o_instr_req(b_req),
        .i_instr_valid(instr_valid), .i_stall(stall), .o_pc_out(b_pc),
        .i_br_valid(br_valid), .i_br_id(br_id), .i_br_pc(br_pc[7:0]),
        .i_br_out(br_out), .i_br_warn(br_warn), .o_flush(b_flush),
        .o_ra_we(b_we), .o_ra_addr(b_raddr), .o_ra_data(b_rad),
        .o_halted(b_halted), .o_redirect_cnt(b_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        st;
        logic        bv;
        logic [31:0] id;
        logic [31:0] bpc;
        logic [31:0] bout;
        logic        warn;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_fl;
        logic        e_we;
        logic [31:0] e_rad;
        logic        e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic st, logic bv, logic [31:0] id,
                                logic [31:0] bpc, logic [31:0] bout, logic warn,
                                logic [31:0] e_pc, logic e_req, logic e_fl,
                                logic e_we, logic [31:0] e_rad, logic e_halt,
                                logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.st = st; r.bv = bv; r.id = id; r.bpc = bpc; r.bout = bout;
        r.warn = warn; r.e_pc = e_pc; r.e_req = e_req; r.e_fl = e_fl;
        r.e_we = e_we; r.e_rad = e_rad; r.e_halt = e_halt; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic v, logic st, logic bv, logic [31:0] id,
                         logic [31:0] bpc, logic [31:0] bout, logic warn);
        instr_valid = v; stall = st; br_valid = bv; br_id = id;
        br_pc = bpc; br_out = bout; br_warn = warn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(string tag);
        chk({tag, " pc"},      a_pc, 32'd0);
        chk({tag, " req"},     {31'd0, a_req}, 32'd0);
        chk({tag, " flush"},   {31'd0, a_flush}, 32'd0);
        chk({tag, " ra_we"},   {31'd0, a_we}, 32'd0);
        chk({tag, " ra_data"}, a_rad, 32'd0);
        chk({tag, " halted"},  {31'd0, a_halted}, 32'd0);
        chk({tag, " cnt"},     {16'd0, a_cnt}, 32'd0);
    endtask

    initial begin
        //        v     st    bv    id      bpc     bout          w     pc        req   fl    we    rad     halt  cnt
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd1,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd2,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd2,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd3,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd15, 32'd4,  32'd0,   1'b0, 32'd4,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd16, 32'd4,  32'd2,   1'b0, 32'd7,   1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 16'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd21, 32'd0,  32'd100, 1'b0, 32'd7,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd8,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd21, 32'd0,  32'd100, 1'b0, 32'd100, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 16'd2));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd100, 1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd2));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 32'd22, 32'd0,  32'd5,   1'b0, 32'd5,   1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 16'd3));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd5,   1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 16'd3));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'd23, 32'd10, 32'd100, 1'b0, 32'd100, 1'b0, 1'b1, 1'b1, 32'd11, 1'b0, 16'd4));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd100, 1'b1, 1'b0, 1'b0, 32'd11, 1'b0, 16'd4));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'd5,  32'd0,  32'd3,   1'b0, 32'd100, 1'b1, 1'b0, 1'b0, 32'd11, 1'b0, 16'd4));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd21, 32'd0,  32'd101, 1'b0, 32'd101, 1'b0, 1'b1, 1'b0, 32'd11, 1'b0, 16'd5));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0,   1'b0, 32'd101, 1'b1, 1'b0, 1'b0, 32'd11, 1'b0, 16'd5));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd16, 32'd0,  32'd2,   1'b1, 32'd101, 1'b0, 1'b0, 1'b0, 32'd11, 1'b1, 16'd5));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'd21, 32'd0,  32'd3,   1'b0, 32'd101, 1'b0, 1'b0, 1'b0, 32'd11, 1'b1, 16'd5));

        clk = 1'b0;
        reset = 1'b1;
        reset_b = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        #12;
        chk_a_reset("reset");
        chk("reset ra_addr", {27'd0, a_raddr}, 32'd31);
        reset = 1'b0;
        step();
        chk("idle->fetch req", {31'd0, a_req}, 32'd1);
        chk("idle->fetch pc", a_pc, 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].st, tbl[i].bv, tbl[i].id, tbl[i].bpc, tbl[i].bout, tbl[i].warn);
            step();
            chk($sformatf("vec%0d pc", i),      a_pc, tbl[i].e_pc);
            chk($sformatf("vec%0d req", i),     {31'd0, a_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("vec%0d flush", i),   {31'd0, a_flush}, {31'd0, tbl[i].e_fl});
            chk($sformatf("vec%0d ra_we", i),   {31'd0, a_we}, {31'd0, tbl[i].e_we});
            chk($sformatf("vec%0d ra_data", i), a_rad, tbl[i].e_rad);
            chk($sformatf("vec%0d halted", i),  {31'd0, a_halted}, {31'd0, tbl[i].e_halt});
            chk($sformatf("vec%0d cnt", i),     {16'd0, a_cnt}, {16'd0, tbl[i].e_cnt});
        end

        // Reset out of HALT, then reset asserted asynchronously mid-REDIRECT after a jal.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk_a_reset("halt reset");
        reset = 1'b0;
        step();
        drive(1'b0, 1'b0, 1'b1, 32'd23, 32'd10, 32'd50, 1'b0);
        step();
        chk("jal2 flush", {31'd0, a_flush}, 32'd1);
        chk("jal2 ra_we", {31'd0, a_we}, 32'd1);
        chk("jal2 pc", a_pc, 32'd50);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_a_reset("async reset mid-redirect");

        // 8-bit PC wrap-around.
        reset_b = 1'b0;
        step();
        chk("w8 fetch req", {31'd0, b_req}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'd21, 32'd0, 32'd255, 1'b0);
        step();
        chk("w8 jump pc", {24'd0, b_pc}, 32'd255);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        chk("w8 seq wrap pc", {24'd0, b_pc}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'd15, 32'd250, 32'd10, 1'b0);
        step();
        chk("w8 branch wrap pc", {24'd0, b_pc}, 32'd5);
        chk("w8 branch flush", {31'd0, b_flush}, 32'd1);
        chk("w8 cnt", {16'd0, b_cnt}, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 32'd17, 32'd20, 32'hFFFF_FFFD, 1'b0);
        step();
        chk("w8 negative offset pc", {24'd0, b_pc}, 32'd18);
        chk("w8 cnt2", {16'd0, b_cnt}, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
